// File: rtl/event_debounce_pulser.sv
`default_nettype none
// ============================================================================
// Module   : event_debounce_pulser
// Brief    : Synchronises and debounces a bouncy async input; emits one pulse
//            per qualified rising edge. Define DEBOUNCE_AUTOREPEAT_EN for
//            periodic repeat pulses while the debounced level stays high.
// Revision : 1.0 - initial release
// ============================================================================
module event_debounce_pulser #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic pulse
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
            $error("event_debounce_pulser: parameter out of legal range");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   w_s_in;
    logic                   w_differs;
    logic                   w_commit;
    logic                   w_repeat;

    assign w_s_in    = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_s_in != level);
    // Commit on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_commit  = w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_differs || w_commit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            if (w_commit) begin
                level <= w_s_in;
            end
            pulse <= (w_commit && w_s_in) || w_repeat;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int                 c_RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

    logic [c_RPT_W-1:0] r_rpt;

    // A commit while level is high is a falling commit: it suppresses repeats.
    assign w_repeat = level && !w_commit && (r_rpt == c_RPT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt <= '0;
        end else if (!level || w_commit || (r_rpt == c_RPT_LAST)) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= r_rpt + 1'b1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_event_debounce_pulser.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_debounce_pulser
// Brief    : Directed bench; expected pulse/level events are queued from the
//            stimulus timing and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_debounce_pulser;

    localparam int c_SYNC = 2;
    localparam int c_DEB  = 16;
    localparam int c_RPT  = 64;
    // Cycles from driving raw_in (after a sample point) to the first sample
    // where level reflects it: one edge to first capture plus SYNC+DEB-1.
    localparam int c_LAT  = c_SYNC + c_DEB;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic raw_in = 1'b0;
    logic level;
    logic pulse;

    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_level = 1'b0;
    logic [3:0] evt_count = '0;

    int   pulse_q[$];
    int   lvl_cyc_q[$];
    logic lvl_val_q[$];

    event_debounce_pulser #(
        .SYNC_STAGES    (c_SYNC),
        .DEBOUNCE_CYCLES(c_DEB),
        .REPEAT_CYCLES  (c_RPT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .raw_in(raw_in),
        .level (level),
        .pulse (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_level(input int at, input logic val);
        lvl_cyc_q.push_back(at);
        lvl_val_q.push_back(val);
    endtask

    task automatic tick(input int n);
        logic exp_pulse;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (lvl_cyc_q.size() > 0 && lvl_cyc_q[0] == cyc) begin
                exp_level = lvl_val_q.pop_front();
                void'(lvl_cyc_q.pop_front());
            end
            exp_pulse = (pulse_q.size() > 0 && pulse_q[0] == cyc);
            if (exp_pulse) void'(pulse_q.pop_front());
            check("level", level, exp_level);
            check("pulse", pulse, exp_pulse);
            if (pulse === 1'b1) evt_count = evt_count + 4'd1;
        end
    endtask

    initial begin
        // 1. Reset, then idle low.
        reset = 1'b1;
        raw_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(50);

        // 2. Clean press, then release (no pulse on release).
        raw_in = 1'b1;
        pulse_q.push_back(cyc + c_LAT);
        expect_level(cyc + c_LAT, 1'b1);
        tick(60);
        raw_in = 1'b0;
        expect_level(cyc + c_LAT, 1'b0);
        tick(30);

        // 3. Glitch shorter than the debounce window.
        raw_in = 1'b1;
        tick(10);
        raw_in = 1'b0;
        tick(30);

        // 4. Bounce every 3 cycles, then steady high; full latency from last rise.
        evt_count = '0;
        for (int t = 0; t < 10; t++) begin
            raw_in = ~raw_in;
            tick(3);
        end
        raw_in = 1'b1;
        pulse_q.push_back(cyc + c_LAT);
        expect_level(cyc + c_LAT, 1'b1);
        tick(40);
        check_int("bounce_event_count", int'(evt_count), 1);

        // 5a. Release from level=1.
        raw_in = 1'b0;
        expect_level(cyc + c_LAT, 1'b0);
        tick(30);

        // 5b. Press, reset mid-count, raw_in kept high: fresh event after release.
        raw_in = 1'b1;
        tick(c_SYNC + 7);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        pulse_q.push_back(cyc + c_LAT);
        expect_level(cyc + c_LAT, 1'b1);
        tick(40);
        raw_in = 1'b0;
        expect_level(cyc + c_LAT, 1'b0);
        tick(30);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // 6. Long hold with auto-repeat.
        begin
            int t0;
            raw_in = 1'b1;
            t0 = cyc + c_LAT;
            for (int k = 0; k < 4; k++) pulse_q.push_back(t0 + k * c_RPT);
            expect_level(t0, 1'b1);
            tick(c_LAT + 200);
            raw_in = 1'b0;
            expect_level(cyc + c_LAT, 1'b0);
            tick(40);
        end
`endif

        check_int("pulse_queue_empty", pulse_q.size(), 0);
        check_int("level_queue_empty", lvl_cyc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_debounce_pulser.md
Name: event_debounce_pulser

Overview:
- Input-conditioning stage directly upstream of the 4-bit event counter; its `pulse` output drives the counter's `enable`.
- Takes an asynchronous, bouncy external signal (pushbutton or sensor) and synchronises it to `clk`.
- Debounces it with a stability counter and emits exactly one single-cycle pulse per qualified rising edge.
- The counter therefore increments once per physical event.

Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive synchronised samples that must differ from `level` before `level` changes; legal range ≥2.
- REPEAT_CYCLES, 64: auto-repeat period in clocks; used only when DEBOUNCE_AUTOREPEAT_EN is defined; legal range ≥2.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  1  asynchronous external event input; no timing relation to clk.
- level  output  1  debounced, registered state of raw_in.
- pulse  output  1  registered single-cycle strobe on each debounced 0->1 transition; feeds the counter enable.

Behaviour:
- Reset (sampled at posedge clk while reset=1) clears to 0:
  - all synchroniser flops;
  - the stability counter, width $clog2(DEBOUNCE_CYCLES+1);
  - level and pulse;
  - the repeat timer.
- Reset has priority over every other event in the same cycle.
- Synchroniser:
  - raw_in shifts through SYNC_STAGES flops;
  - s_in is the last stage;
  - no logic between stages.
- Stability counter:
  - If s_in == level: counter <= 0.
  - If s_in != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s_in != level and counter == DEBOUNCE_CYCLES-1: level <= s_in, counter <= 0.
  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- pulse:
  - Asserted for exactly one cycle, in the same cycle that level first reads 1 after a 0->1 commit.
  - Held at 0 on 1->0 commits and at all other times.
- Latency:
  - raw_in steady high, first sampled at edge E.
  - level and pulse read 1 after edge E + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - With defaults: 17 edges after E, i.e. in the 18th cycle.
  - Falling latency is identical; no pulse on the fall.
- Glitch rejection:
  - Any s_in excursion shorter than DEBOUNCE_CYCLES samples returns the counter to 0; level is unchanged.
  - Bounce restarts the count on every reversal.
- Reset mid-operation:
  - Discards any partial count and any pending transition.
  - If raw_in is still high after reset releases, it is treated as a fresh rising event: one pulse after full latency.
- level and pulse are glitch-free registered outputs; pulse is never high for 2 consecutive cycles unless auto-repeat is enabled with REPEAT_CYCLES=1, which is illegal.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - A repeat timer runs while level==1.
  - After the initial pulse at cycle T0, pulse also fires at T0+REPEAT_CYCLES, T0+2*REPEAT_CYCLES, and so on, while level stays 1.
  - Timer clears to 0 when level falls or on reset.
  - Each repeat pulse is exactly 1 cycle wide.
- Not defined:
  - No repeat timer logic is instantiated.
  - Exactly one pulse per debounced press.
  - REPEAT_CYCLES is ignored.

Test Plan:
1. Reset: raw_in=0, reset=1 for 3 cycles, then release and hold raw_in=0 for 50 cycles -> level=0 and pulse=0 throughout.
2. Clean press (defaults): raw_in 0->1, held 60 cycles -> pulse=1 for exactly one cycle, 17 edges after the first sampling edge; level=1 from that cycle onward; no further pulses.
3. Glitch: raw_in high for 10 cycles, then low -> level stays 0, pulse never asserts, counter returns to 0.
4. Bounce: raw_in toggles every 3 cycles for 30 cycles, then steady high -> exactly one pulse, timed 17 edges after the final rising sample; an attached counter shows out=1.
5. Release and reset-mid-count:
   - level=1, raw_in->0 -> level falls after 17 edges with no pulse.
   - Then raw_in->1 with reset asserted at the 8th debounce cycle and raw_in kept high -> no pulse during reset; one pulse at full latency after reset release.
6. With DEBOUNCE_AUTOREPEAT_EN and REPEAT_CYCLES=64: raw_in held high 200 cycles past the first pulse -> pulses at T0, T0+64, T0+128, T0+192, each 1 cycle wide; no pulse after release.
